// File: rtl/prio_pkg.sv
// Shared definitions for the priority arbiter: offer FSM states, mode codes
// and the address-width helper.
package prio_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Address width for a given number of request lines; never below one bit.
  function automatic int aw_of(input int width);
    int aw;
    aw = $clog2(width);
    return (aw < 1) ? 1 : aw;
  endfunction

endpackage

// File: rtl/prio_arbiter_pick_highest.sv
// Combinational highest-set-index finder; found is low when the vector is empty
// and idx is then 0.
module pick_highest #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic [AW-1:0]    idx,
  output logic             found
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = AW'(i);
    end
  end

  assign found = |vec;

endmodule

// File: rtl/prio_arbiter.sv
// Registered priority arbiter: latches requests into a pending vector and offers
// one index at a time under valid/ready, fixed or round-robin priority.
//
//   state | meaning
//   IDLE  | no live offer, valid_o low, addr_o holds the last grant
//   OFFER | addr_o is offered and held until accepted or cleared
module prio_arbiter
  import prio_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int AW    = aw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_i,
  input  logic             mode_i,
  input  logic             clear_i,
  input  logic             ready_i,
  output logic [AW-1:0]    addr_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] pending_o,
  output logic             drop_o
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pending;
  logic [AW-1:0]    r_ptr;
  logic [AW-1:0]    r_addr;
  logic             r_drop;

  logic             w_acc;
  logic             w_load;
  logic [WIDTH-1:0] w_cons;
  logic [WIDTH-1:0] w_pnext;
  logic [WIDTH-1:0] w_lemask;
  logic [AW-1:0]    w_ptr_eff;
  logic [AW-1:0]    w_idx_m;
  logic [AW-1:0]    w_idx_u;
  logic [AW-1:0]    w_sel;
  logic             w_found_m;
  logic             w_found_u;

  assign w_acc   = (r_state == OFFER) & ready_i;
  assign w_cons  = w_acc ? ({{(WIDTH-1){1'b0}}, 1'b1} << r_addr) : '0;
  assign w_pnext = (r_pending & ~w_cons) | req_i;

  // Selection looks at the pointer as it stands after this cycle's accept,
  // so the just-served index drops to lowest priority immediately.
  assign w_ptr_eff = !w_acc            ? r_ptr :
                     (r_addr == '0)    ? AW'(WIDTH - 1) :
                                         r_addr - AW'(1);

  always_comb begin
    w_lemask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_lemask[i] = (AW'(i) <= w_ptr_eff);
    end
  end

  pick_highest #(.WIDTH(WIDTH), .AW(AW)) u_pick_masked (
    .vec   (w_pnext & w_lemask),
    .idx   (w_idx_m),
    .found (w_found_m)
  );

  pick_highest #(.WIDTH(WIDTH), .AW(AW)) u_pick_all (
    .vec   (w_pnext),
    .idx   (w_idx_u),
    .found (w_found_u)
  );

  assign w_sel = (mode_i == MODE_RR && w_found_m) ? w_idx_m : w_idx_u;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found_u) begin
          w_state_nxt = OFFER;
          w_load      = 1'b1;
        end
      end
      OFFER: begin
        if (w_acc) begin
          w_state_nxt = w_found_u ? OFFER : IDLE;
          w_load      = w_found_u;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_ptr     <= AW'(WIDTH - 1);
      r_addr    <= '0;
      r_drop    <= 1'b0;
    end else if (clear_i) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pnext;
      r_ptr     <= w_ptr_eff;
      r_drop    <= |(req_i & r_pending & ~w_cons);
      if (w_load) r_addr <= w_sel;
    end
  end

  assign addr_o    = r_addr;
  assign valid_o   = (r_state == OFFER);
  assign pending_o = r_pending;
  assign drop_o    = r_drop;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter: a spec-level model checked every cycle on the
// 16-wide instance, plus hand-computed expectations on 16- and 5-wide instances.
module tb_prio_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [15:0] req_i   = '0;
  logic        mode_i  = 1'b0;
  logic        clear_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [3:0]  addr_o;
  logic        valid_o;
  logic [15:0] pending_o;
  logic        drop_o;

  logic [4:0]  req5   = '0;
  logic        mode5  = 1'b0;
  logic        clear5 = 1'b0;
  logic        ready5 = 1'b0;
  logic [2:0]  addr5;
  logic        valid5;
  logic [4:0]  pending5;
  logic        drop5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  prio_arbiter #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .req_i(req_i), .mode_i(mode_i), .clear_i(clear_i),
    .ready_i(ready_i), .addr_o(addr_o), .valid_o(valid_o),
    .pending_o(pending_o), .drop_o(drop_o)
  );

  prio_arbiter #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .req_i(req5), .mode_i(mode5), .clear_i(clear5),
    .ready_i(ready5), .addr_o(addr5), .valid_o(valid5),
    .pending_o(pending5), .drop_o(drop5)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: search downward from the pointer with wraparound, or from the top.
  function automatic int m_pick(input logic [15:0] v, input bit rr, input int ptr, input int w);
    int idx;
    if (rr) begin
      for (int k = 0; k < w; k++) begin
        idx = ptr - k;
        if (idx < 0) idx += w;
        if (v[idx]) return idx;
      end
    end else begin
      for (int j = w - 1; j >= 0; j--) if (v[j]) return j;
    end
    return -1;
  endfunction

  logic [15:0] m_pend;
  bit          m_valid, m_drop, m_init = 0;
  int          m_addr, m_ptr;

  always @(posedge clk) begin
    logic [15:0] np;
    bit          acc;
    int          pick;
    if (rst) begin
      m_pend = '0; m_valid = 0; m_addr = 0; m_ptr = 15; m_drop = 0; m_init = 1;
    end else if (clear_i) begin
      m_pend = '0; m_valid = 0; m_drop = 0;
    end else begin
      acc    = m_valid && ready_i;
      np     = m_pend;
      m_drop = 0;
      for (int i = 0; i < 16; i++) begin
        if (acc && i == m_addr) np[i] = 1'b0;
        if (req_i[i] && np[i]) m_drop = 1;
        if (req_i[i]) np[i] = 1'b1;
      end
      if (acc) m_ptr = (m_addr == 0) ? 15 : m_addr - 1;
      if (!m_valid || acc) begin
        pick = m_pick(np, mode_i, m_ptr, 16);
        if (pick >= 0) begin
          m_addr  = pick;
          m_valid = 1;
        end else begin
          m_valid = 0;
        end
      end
      m_pend = np;
    end
  end

  always @(negedge clk) begin
    if (m_init && !rst) begin
      chk("cmp_valid",   valid_o,   m_valid);
      chk("cmp_addr",    addr_o,    m_addr);
      chk("cmp_pending", pending_o, m_pend);
      chk("cmp_drop",    drop_o,    m_drop);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    chk("model_rr_wrap_to_0",  m_pick(16'h8001, 1, 14, 16), 0);
    chk("model_fixed_15",      m_pick(16'h8001, 0, 14, 16), 15);
    chk("model_rr_search_wrap", m_pick(16'h0100, 1, 3, 16), 8);
    chk("model_w5_rr",         m_pick(16'h0011, 1, 3, 5), 0);

    cyc(2);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("idle_valid", valid_o, 0);
      chk("idle_addr", addr_o, 0);
      chk("idle_pending", pending_o, 0);
      chk("idle_drop", drop_o, 0);
    end

    mode_i = 1'b0; ready_i = 1'b1; req_i = 16'h0024;
    cyc(1); req_i = '0;
    chk("drain_first", {valid_o, addr_o}, {1'b1, 4'd5});
    cyc(1);
    chk("drain_second", {valid_o, addr_o}, {1'b1, 4'd2});
    cyc(1);
    chk("drain_done_valid", valid_o, 0);
    chk("drain_done_pending", pending_o, 0);

    ready_i = 1'b0; req_i = 16'h8001;
    cyc(1); req_i = '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {valid_o, addr_o}, {1'b1, 4'd15});
      if (i < 4) cyc(1);
    end
    ready_i = 1'b1;
    cyc(1);
    chk("bp_second", {valid_o, addr_o}, {1'b1, 4'd0});
    cyc(1);
    chk("bp_idle", valid_o, 0);

    mode_i = 1'b0; req_i = 16'h8001;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("fixed_15", {valid_o, addr_o}, {1'b1, 4'd15});
    end
    mode_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("rr_alt", addr_o, (i % 2 == 0) ? 4'd0 : 4'd15);
    end
    req_i = '0;
    cyc(4);
    chk("rr_drained", valid_o, 0);
    mode_i = 1'b0;

    ready_i = 1'b0; req_i = 16'h0008;
    cyc(1);
    chk("drop_first_edge", drop_o, 0);
    cyc(1); req_i = '0;
    chk("drop_second_edge", drop_o, 1);
    chk("drop_pending", pending_o, 16'h0008);
    cyc(1);
    chk("drop_one_cycle", drop_o, 0);
    ready_i = 1'b1; req_i = 16'h0008;
    cyc(1); req_i = '0;
    chk("rereq_no_drop", drop_o, 0);
    chk("rereq_pending", pending_o, 16'h0008);
    chk("rereq_offer", {valid_o, addr_o}, {1'b1, 4'd3});
    cyc(1);
    chk("rereq_drained", valid_o, 0);

    ready_i = 1'b0; req_i = 16'h00F0;
    cyc(1); req_i = '0;
    chk("clr_pre_pending", pending_o, 16'h00F0);
    chk("clr_pre_offer", {valid_o, addr_o}, {1'b1, 4'd7});
    clear_i = 1'b1; req_i = 16'h0001; ready_i = 1'b1;
    cyc(1); clear_i = 1'b0; req_i = '0; ready_i = 1'b0;
    chk("clr_valid", valid_o, 0);
    chk("clr_pending", pending_o, 0);
    chk("clr_addr_kept", addr_o, 7);
    cyc(1);
    chk("clr_stays_idle", valid_o, 0);

    mode5 = 1'b1; ready5 = 1'b1; req5 = 5'b10001;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("w5_rr", {valid5, addr5}, {1'b1, (i % 2 == 0) ? 3'd4 : 3'd0});
    end
    req5 = '0;
    cyc(3);
    chk("w5_idle", valid5, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_arbiter.md
# prio_arbiter

Parametrised, registered successor to the team's 16-input priority encoder. It latches incoming one-bit requests into a pending vector and selects one index per grant, by fixed (highest-index) or round-robin priority. Each grant is offered as a registered address under a valid/ready handshake. It sits between request sources (buttons, status flags) and a single downstream consumer that serves one index at a time.

## Interface
- `WIDTH`, default 16, number of request lines; legal range 2..64; need not be a power of two.
- `AW`, localparam = $clog2(WIDTH), address width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `req_i`  in  WIDTH  request pulses or levels; bit i requests index i.
- `mode_i`  in  1  0 = fixed priority (highest index wins); 1 = round-robin.
- `clear_i`  in  1  synchronous flush of pending and offer.
- `ready_i`  in  1  consumer accepts `addr_o` this cycle.
- `addr_o`  out  AW  granted index, registered.
- `valid_o`  out  1  `addr_o` is a live offer, registered.
- `pending_o`  out  WIDTH  pending register, including the offered bit.
- `drop_o`  out  1  registered one-cycle pulse: a request merged into an already-pending bit.

## Operation
- **Accept event.** `acc = valid_o & ready_i`.
- **Consume mask.** `cons = acc ? onehot(addr_o) : 0`.
- **Pending update.** `pnext = (pending & ~cons) | req_i`. `pending <= pnext` every cycle. A request for the bit being consumed in the same cycle stays pending.
- **Selection.** Combinational, applied to `pnext`.
  - mode 0: highest set index.
  - mode 1: highest set index ≤ `ptr`. If there is none, the highest set index overall (wrap).
- **Offer FSM, states IDLE and OFFER.**
  - IDLE or (OFFER & acc):
    - if `pnext != 0`: load `addr_o` = selection, `valid_o` <= 1, go to OFFER;
    - else `valid_o` <= 0, go to IDLE, and `addr_o` holds its last value.
  - OFFER & !ready_i: `addr_o` and `valid_o` hold. Changes on `mode_i` or `req_i` never disturb a live offer.
- **Round-robin pointer `ptr`.**
  - On acc, `ptr <= (addr_o == 0) ? WIDTH-1 : addr_o-1`.
  - `ptr` updates in both modes, so switching to mode 1 resumes fairly.
- **Drop detection.** `drop_o <= |(req_i & pending & ~cons)`.
- **Clear.** `clear_i` takes priority over everything except `rst`:
  - `pending` <= 0, `valid_o` <= 0, `drop_o` <= 0, state IDLE;
  - `req_i` in that cycle is discarded;
  - `ptr` and `addr_o` are retained.
- **Reset values.**
  - `addr_o` = 0, `valid_o` = 0, `pending_o` = 0, `drop_o` = 0.
  - `ptr` = WIDTH-1, so round-robin's first choice equals fixed priority.
  - state = IDLE.

## Timing
- **Request latency.** `req_i` sampled at edge E gives `valid_o`/`addr_o` after edge E (visible in cycle E+1), if idle.
- **Throughput.** With `ready_i` held high, one grant per cycle, back to back, no bubble.
- **Handshake rules.**
  - `valid_o` never drops without acc or clear.
  - `addr_o` is stable while `valid_o & !ready_i`.
  - `ready_i` while `valid_o = 0` has no effect.
- **`pending_o`** reflects the register, so the offered bit reads 1 until the edge that accepts it.
- **Simultaneous events.**
  - `rst` beats `clear_i`; `clear_i` beats acc and `req_i`.
  - acc and a re-request of the same bit in one cycle give no drop, and the bit re-enters pending.
- **Non-power-of-two WIDTH.** `ptr` wraps 0 → WIDTH-1. Addresses ≥ WIDTH are never produced.

## Structure
- **Shared package `prio_pkg`.**
  - FSM state encoding (IDLE = 0, OFFER = 1).
  - `AW` computation helper.
  - `MODE_FIXED` / `MODE_RR` constants.
- **Sub-module `pick_highest`.**
  - Parametrised on WIDTH; combinational; outputs `idx` and `found`.
  - Instantiated twice: once on `pnext & lemask(ptr)`, once on `pnext`.
  - Round-robin result = the masked pick if found, else the unmasked pick. Fixed mode uses the unmasked pick.
- **Top level** holds `pending`, `ptr`, the FSM, and the output registers.

## Test plan
- **Reset and idle.** Reset, then `req_i` = 0 for 10 cycles → `valid_o` = 0, `addr_o` = 0, `pending_o` = 0, `drop_o` = 0 throughout.
- **Fixed-priority drain.** WIDTH = 16, mode 0, `ready_i` = 1, `req_i` = 16'h0024 for one cycle → `addr_o` 5 (valid), then 2 (valid), then `valid_o` = 0 and `pending_o` = 0.
- **Backpressure.** `req_i` = 16'h8001 once, `ready_i` = 0 for 5 cycles → `addr_o` = 15 held with `valid_o` = 1. Raise `ready_i` → grants 15 then 0, then idle.
- **Fixed versus round-robin.** `req_i` held at 16'h8001, `ready_i` = 1:
  - mode 0 → grants 15,15,15…;
  - mode 1 → grants 15,0,15,0…;
  - WIDTH = 5, mode 1, `req_i` = 5'b10001 held → grants 4,0,4,0, and `ptr` wraps 0 → 4.
- **Drop detection.** `ready_i` = 0, `req_i` = 16'h0008 for two consecutive cycles → `drop_o` = 1 for exactly one cycle, after the second edge. `pending_o` = 16'h0008.
- **Clear mid-offer.** `pending_o` = 16'h00F0 and `addr_o` = 7 offered, then `clear_i` = 1 with `req_i` = 16'h0001 → next cycle `valid_o` = 0, `pending_o` = 0, bit 0 not captured, `addr_o` still reads 7.
